// File: rtl/toggle_port_responder_if.sv
// Toggle-handshake request port plus the level-req/grant backend port of the responder.
// The requester/backend side drives through master; the responder uses slave.
interface toggle_port_responder_if #(
  parameter int AW = 23,
  parameter int DW = 16
);
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [DW-1:0] port_d;
  logic [DW-1:0] port_q;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_be;
  logic [DW-1:0] mem_din;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_dout;

  modport master (
    output port_req, port_a, port_ds, port_we, port_d,
    input  port_ack, port_q,
    input  mem_req, mem_we, mem_addr, mem_be, mem_din,
    output mem_gnt, mem_rvalid, mem_dout
  );

  modport slave (
    input  port_req, port_a, port_ds, port_we, port_d,
    output port_ack, port_q,
    output mem_req, mem_we, mem_addr, mem_be, mem_din,
    input  mem_gnt, mem_rvalid, mem_dout
  );
endinterface

// File: rtl/toggle_port_responder.sv
// Responder for the toggle req/ack memory port: one backend access per req toggle,
// ack toggled on completion, read data on port_q, transfer counter and violation flag.
module toggle_port_responder #(
  parameter int AW = 23,
  parameter int DW = 16
) (
  input  logic                  clk,
  input  logic                  init_n,
  toggle_port_responder_if.slave bus,
  input  logic                  err_clr,
  output logic                  req_err,
  output logic [15:0]           xfer_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          req_dly_q;
  logic          ack_q, ack_d;
  logic [DW-1:0] q_q, q_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]    mem_be_q, mem_be_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_set;

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    q_d        = q_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d   = mem_be_q;
    mem_din_d  = mem_din_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.port_req != ack_q) begin
          // A write with no byte lanes has nothing to do at the backend.
          if (bus.port_we && (bus.port_ds == 2'b00)) begin
            ack_d = bus.port_req;
            cnt_d = cnt_q + 16'd1;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = bus.port_we;
            mem_addr_d = bus.port_a;
            mem_be_d   = bus.port_ds;
            mem_din_d  = bus.port_d;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            ack_d   = bus.port_req;
            cnt_d   = cnt_q + 16'd1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        if (bus.mem_rvalid) begin
          q_d     = bus.mem_dout;
          ack_d   = bus.port_req;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // In IDLE, an edge while the previous sample already differed from ack is a double toggle.
  assign err_set = (bus.port_req != req_dly_q) &&
                   ((state_q != S_IDLE) || (req_dly_q != ack_q));
  assign err_d   = err_set | (err_q & ~err_clr);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q    <= S_IDLE;
      req_dly_q  <= 1'b0;
      ack_q      <= 1'b0;
      q_q        <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q   <= 2'b00;
      mem_din_q  <= '0;
      err_q      <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      req_dly_q  <= bus.port_req;
      ack_q      <= ack_d;
      q_q        <= q_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q   <= mem_be_d;
      mem_din_q  <= mem_din_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.port_ack = ack_q;
  assign bus.port_q   = q_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_be   = mem_be_q;
  assign bus.mem_din  = mem_din_q;
  assign req_err      = err_q;
  assign xfer_cnt     = cnt_q;

endmodule

// File: tb/tb_toggle_port_responder.sv
// Directed bench for toggle_port_responder: scoreboard of expected completions, checked on each ack.
module tb_toggle_port_responder;
  localparam int AW = 23;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        init_n;
  logic        err_clr;
  logic        req_err;
  logic [15:0] xfer_cnt;

  toggle_port_responder_if #(.AW(AW), .DW(DW)) bus ();

  toggle_port_responder #(.AW(AW), .DW(DW)) u_dut (
    .clk      (clk),
    .init_n   (init_n),
    .bus      (bus),
    .err_clr  (err_clr),
    .req_err  (req_err),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [15:0] exp_q   = 16'd0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  // Drive a new request (toggle) and record what its completion must look like.
  task automatic push_req(input logic we, input logic [1:0] ds, input logic [22:0] a,
                          input logic [15:0] d, input logic [15:0] rdata);
    bus.port_we  = we;
    bus.port_ds  = ds;
    bus.port_a   = a;
    bus.port_d   = d;
    bus.port_req = ~bus.port_req;
    exp_cnt      = exp_cnt + 16'd1;
    if (!we) exp_q = rdata;
    sb.push_back('{q: exp_q, cnt: exp_cnt});
  endtask

  task automatic complete(input string tag, input int budget, input bit quiet, output int ncyc);
    exp_t e;
    ncyc = 0;
    while ((bus.port_ack !== bus.port_req) && (ncyc < budget)) begin
      cycle();
      ncyc++;
    end
    check({tag, "_ack"}, 32'(bus.port_ack), 32'(bus.port_req));
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_q"}, 32'(bus.port_q), 32'(e.q));
      check({tag, "_cnt"}, 32'(xfer_cnt), 32'(e.cnt));
      if (!quiet)
        $display("xfer %s: q=0x%h cnt=%0d cycles=%0d", tag, bus.port_q, xfer_cnt, ncyc);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    int  total;
    logic ack_before;

    init_n         = 1'b0;
    err_clr        = 1'b0;
    bus.port_req   = 1'b0;
    bus.port_a     = '0;
    bus.port_ds    = 2'b00;
    bus.port_we    = 1'b0;
    bus.port_d     = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_dout   = '0;

    repeat (3) cycle();
    check("rst_ack",      32'(bus.port_ack), 32'h0);
    check("rst_q",        32'(bus.port_q),   32'h0);
    check("rst_mem_req",  32'(bus.mem_req),  32'h0);
    check("rst_mem_we",   32'(bus.mem_we),   32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_mem_be",   32'(bus.mem_be),   32'h0);
    check("rst_mem_din",  32'(bus.mem_din),  32'h0);
    check("rst_req_err",  32'(req_err),      32'h0);
    check("rst_xfer_cnt", 32'(xfer_cnt),     32'h0);
    $display("reset: done");
    init_n = 1'b1;
    cycle();

    // Single write, grant tied high: ack two cycles after the toggle.
    bus.mem_gnt = 1'b1;
    push_req(1'b1, 2'b01, 23'h012345, 16'hABCD, 16'h0);
    cycle();
    check("wr1_mem_req",  32'(bus.mem_req),  32'h1);
    check("wr1_mem_be",   32'(bus.mem_be),   32'h1);
    check("wr1_mem_addr", 32'(bus.mem_addr), 32'h012345);
    check("wr1_mem_din",  32'(bus.mem_din),  32'hABCD);
    check("wr1_mem_we",   32'(bus.mem_we),   32'h1);
    check("wr1_ack_early", 32'(bus.port_ack), 32'h0);
    cycle();
    check("wr1_mem_req_drop", 32'(bus.mem_req), 32'h0);
    complete("wr1", 0, 1'b0, n);

    // Backend strobes while idle must not disturb anything.
    bus.mem_rvalid = 1'b1;
    bus.mem_dout   = 16'h1111;
    cycle();
    bus.mem_rvalid = 1'b0;
    check("idle_rvalid_q", 32'(bus.port_q), 32'h0);
    check("idle_gnt_req",  32'(bus.mem_req), 32'h0);

    // Read: grant 5 cycles late, rvalid 3 cycles after grant, rvalid in grant cycle ignored.
    bus.mem_gnt = 1'b0;
    ack_before  = bus.port_ack;
    push_req(1'b0, 2'b11, 23'h000777, 16'h0, 16'h5AA5);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rd1_hold_req",  32'(bus.mem_req),  32'h1);
      check("rd1_hold_addr", 32'(bus.mem_addr), 32'h000777);
      check("rd1_hold_be",   32'(bus.mem_be),   32'h3);
      check("rd1_hold_we",   32'(bus.mem_we),   32'h0);
    end
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_dout   = 16'hDEAD;
    cycle();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    check("rd1_req_drop", 32'(bus.mem_req),  32'h0);
    check("rd1_no_ack",   32'(bus.port_ack), 32'(ack_before));
    cycle();
    cycle();
    bus.mem_rvalid = 1'b1;
    bus.mem_dout   = 16'h5AA5;
    check("rd1_ack_wait", 32'(bus.port_ack), 32'(ack_before));
    check("rd1_q_wait",   32'(bus.port_q),   32'h0);
    cycle();
    bus.mem_rvalid = 1'b0;
    complete("rd1", 0, 1'b0, n);

    // Write with no byte lanes: no backend access, ack next cycle.
    bus.mem_gnt = 1'b0;
    push_req(1'b1, 2'b00, 23'h000100, 16'h1234, 16'h0);
    cycle();
    check("wr_ds0_mem_req", 32'(bus.mem_req), 32'h0);
    complete("wr_ds0", 0, 1'b0, n);

    // Protocol violation during RDWAIT: flag is sticky across completion.
    bus.mem_gnt = 1'b1;
    push_req(1'b0, 2'b10, 23'h000200, 16'h0, 16'h1234);
    cycle();
    cycle();
    bus.mem_gnt = 1'b0;
    check("viol_err_before", 32'(req_err), 32'h0);
    bus.port_req = ~bus.port_req;
    cycle();
    check("viol_err_set", 32'(req_err), 32'h1);
    bus.mem_rvalid = 1'b1;
    bus.mem_dout   = 16'h1234;
    cycle();
    bus.mem_rvalid = 1'b0;
    complete("rd_viol", 0, 1'b0, n);
    check("viol_err_sticky", 32'(req_err), 32'h1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("viol_err_clr", 32'(req_err), 32'h0);

    // Violation and clear in the same cycle: set wins.
    push_req(1'b0, 2'b01, 23'h000300, 16'h0, 16'h4321);
    cycle();
    bus.port_req = ~bus.port_req;
    err_clr      = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("viol_clr_same", 32'(req_err), 32'h1);
    bus.mem_gnt = 1'b1;
    cycle();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_dout   = 16'h4321;
    cycle();
    bus.mem_rvalid = 1'b0;
    complete("rd_viol_clr", 0, 1'b0, n);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("viol_clr_final", 32'(req_err), 32'h0);

    // Back-to-back writes toggled in the ack cycle: one per 2 cycles.
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_req(1'b1, 2'b11, 23'(i + 16), 16'(i * 3 + 1), 16'h0);
      complete("b2b", 4, 1'b0, n);
      check("b2b_latency", 32'(n), 32'd2);
    end
    check("b2b_no_err", 32'(req_err), 32'h0);

    // Drive the counter through its wrap with zero-lane writes.
    total = 65536 - int'(exp_cnt);
    for (int i = 0; i < total - 1; i++) begin
      push_req(1'b1, 2'b00, 23'h0, 16'h0, 16'h0);
      complete("wrap", 2, 1'b1, n);
    end
    check("wrap_ffff", 32'(xfer_cnt), 32'h0000FFFF);
    push_req(1'b1, 2'b00, 23'h0, 16'h0, 16'h0);
    complete("wrap_last", 2, 1'b0, n);
    check("wrap_zero", 32'(xfer_cnt), 32'h0);
    check("wrap_no_err", 32'(req_err), 32'h0);

    // Asynchronous reset while a read sits in ISSUE.
    bus.mem_gnt  = 1'b0;
    bus.port_we  = 1'b0;
    bus.port_ds  = 2'b11;
    bus.port_a   = 23'h000400;
    bus.port_req = ~bus.port_req;
    cycle();
    check("arst_pre_req", 32'(bus.mem_req), 32'h1);
    #2;
    init_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(bus.mem_req),  32'h0);
    check("arst_ack",     32'(bus.port_ack), 32'h0);
    check("arst_q",       32'(bus.port_q),   32'h0);
    check("arst_cnt",     32'(xfer_cnt),     32'h0);
    bus.port_req = 1'b0;
    cycle();
    cycle();
    init_n         = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_dout   = 16'hBEEF;
    cycle();
    bus.mem_rvalid = 1'b0;
    cycle();
    check("arst_late_rvalid_q", 32'(bus.port_q),   32'h0);
    check("arst_late_ack",      32'(bus.port_ack), 32'h0);
    check("arst_late_mem_req",  32'(bus.mem_req),  32'h0);
    check("arst_late_cnt",      32'(xfer_cnt),     32'h0);
    check("arst_sb_empty",      32'(sb.size()),    32'h0);
    $display("async reset: done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/toggle_port_responder.md
Name: toggle_port_responder

Overview:
- Responder end of the toggle-handshake memory port used by the ROM download path and the game-side ROM fetch path (req/ack, a, ds, we, d, q).
- Accepts one request per req toggle, issues it to a single-ported level-req/grant memory backend (SDRAM controller core or BRAM wrapper), and toggles ack on completion.
- Returns read data on port_q and counts completed transfers.
- Flags protocol violations, i.e. a second req toggle while a request is in flight.

Parameters:
AW, 23, word address width of port_a / mem_addr
DW, 16, data width; must be 16 (two byte lanes)

Ports:
clk  in  1  system clock; all logic on rising edge
init_n  in  1  asynchronous active-low reset
port_req  in  1  request toggle; new request when port_req != port_ack
port_ack  out  1  acknowledge toggle; set equal to port_req on completion
port_a  in  AW  word address, sampled at acceptance
port_ds  in  2  byte-lane selects {hi,lo}, sampled at acceptance
port_we  in  1  1=write, 0=read, sampled at acceptance
port_d  in  DW  write data, sampled at acceptance
port_q  out  DW  read data of last completed read
mem_req  out  1  level request to backend
mem_we  out  1  backend write enable, valid while mem_req
mem_addr  out  AW  backend address, valid while mem_req
mem_be  out  2  backend byte enables, valid while mem_req
mem_din  out  DW  backend write data, valid while mem_req
mem_gnt  in  1  backend accepts the request in a cycle where mem_req=1 and mem_gnt=1
mem_rvalid  in  1  one-cycle pulse with read data, any cycle after grant
mem_dout  in  DW  backend read data, valid with mem_rvalid
err_clr  in  1  clears req_err
req_err  out  1  sticky protocol-violation flag
xfer_cnt  out  16  completed-transfer counter

Behaviour:
- Reset (init_n=0, async): state IDLE; port_ack=0, port_q=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_din=0, req_err=0, xfer_cnt=0; internal req_d=0.
- Reset mid-operation: the in-flight request is abandoned with no ack, and mem_req drops immediately. A mem_rvalid arriving after reset is ignored.
- port_req is synchronous to clk; no synchronizer. req_d is port_req registered each cycle.
- States: IDLE, ISSUE, RDWAIT.
- IDLE, port_req != port_ack in cycle N:
  - latch a, ds, we, d;
  - if we=1 and ds=00: no memory access; port_ack toggles at N+1; xfer_cnt+1; stay IDLE;
  - otherwise go to ISSUE with mem_req=1 from N+1, mem_be=ds, mem_we=we, mem_addr=a, mem_din=d.
- ISSUE: hold all mem_* stable until the grant cycle G.
  - Write: mem_req=0, port_ack toggles, xfer_cnt+1, all at G+1; next state IDLE.
  - Read: mem_req=0 at G+1; next state RDWAIT.
  - Read with ds=00 is still issued with mem_be=00; the full word is returned.
- RDWAIT, mem_rvalid in cycle R: port_q=mem_dout, port_ack toggles, xfer_cnt+1, all at R+1; next state IDLE.
  - mem_rvalid in the grant cycle itself is ignored.
- Minimum write latency: req toggle to ack toggle = 2 cycles with mem_gnt tied high.
- Back-to-back: the first cycle back in IDLE compares the updated port_ack, so a req toggled in the ack cycle is accepted in that cycle.
- port_q holds its value across writes and idle periods; it changes only on read completion.
- req_err:
  - set when port_req != req_d while state != IDLE, or while in IDLE with a request already pending (a double toggle is indistinguishable from no request and is thereby detected);
  - err_clr=1 clears it; if set and clear occur in the same cycle, set wins.
  - A violating toggle does not start a new transaction; the responder completes the current request and then acks to whatever port_req reads at that time.
- xfer_cnt: 16-bit, wraps FFFF->0000 with no flag.
- mem_gnt or mem_rvalid while IDLE is ignored.

Test Plan:
- Reset, then one write: a=0x012345, ds=01, d=0xABCD, toggle req, mem_gnt tied high -> mem_req high for 1 cycle with be=01, addr=0x012345; port_ack=1 two cycles after toggle; xfer_cnt=1.
- Read with grant delayed 5 cycles and rvalid 3 cycles after grant, mem_dout=0x5AA5 -> mem_* stable through the wait; port_q=0x5AA5 and ack toggle land in the same cycle, R+1.
- Write with ds=00 -> mem_req never asserts; ack toggles at N+1; xfer_cnt increments.
- Second req toggle during RDWAIT -> req_err=1 and stays 1 after completion; err_clr pulse -> 0; err_clr and a violation in the same cycle -> remains 1.
- 65536 zero-wait writes -> xfer_cnt wraps to 0x0000; back-to-back toggles issued in the ack cycle complete at a rate of one write per 2 cycles.
- init_n low while in ISSUE -> mem_req and port_ack are 0 asynchronously; a later mem_rvalid is ignored and port_q stays 0.
